// File: rtl/cei_mochila_pkg.sv
// Shared CPU interconnect types: address-map rule format, CPU xbar rule table and demux constants.
package cei_mochila_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned CPU_XBAR_NSLAVE = 2;
    localparam int unsigned CPU_XBAR_NRULES = 3;

    // Rule 1 has end <= start, so it covers everything from 0xF000_0000 to the top of memory.
    localparam addr_map_rule_t [CPU_XBAR_NRULES-1:0] CPU_XBAR_ADDR_RULES = '{
        2: '{idx: 32'd1, start_addr: 32'hFF00_0000, end_addr: 32'hFF01_0000},
        1: '{idx: 32'd0, start_addr: 32'hF000_0000, end_addr: 32'h0000_0000},
        0: '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h4000_0000}
    };

    localparam int unsigned CPU_DEMUX_MAX_OUTSTANDING = 2;
    localparam logic [31:0] CPU_DEMUX_ERR_RDATA       = 32'hBADA_CCE5;

endpackage

// File: rtl/cei_resp_idx_fifo.sv
// Synchronous FIFO holding the target index of every accepted, not yet answered transaction.
module cei_resp_idx_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cei_cpu_obi_demux.sv
// Per-core OBI 1-to-NSLAVE demux with in-order response return.
// Define CEI_DEMUX_ERR_SLAVE_EN to answer unmapped accesses from an internal error slave.
module cei_cpu_obi_demux
    import cei_mochila_pkg::*;
#(
    parameter int unsigned                 NSLAVE          = CPU_XBAR_NSLAVE,
    parameter int unsigned                 NRULES          = CPU_XBAR_NRULES,
    parameter int unsigned                 MAX_OUTSTANDING = CPU_DEMUX_MAX_OUTSTANDING,
    parameter addr_map_rule_t [NRULES-1:0] ADDR_RULES      = CPU_XBAR_ADDR_RULES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [NSLAVE-1:0]    slv_req_o,
    input  logic [NSLAVE-1:0]    slv_gnt_i,
    output logic [31:0]          slv_addr_o,
    output logic                 slv_we_o,
    output logic [3:0]           slv_be_o,
    output logic [31:0]          slv_wdata_o,
    input  logic [NSLAVE-1:0]    slv_rvalid_i,
    input  logic [NSLAVE*32-1:0] slv_rdata_i,
    output logic                 resp_err_o
);

    localparam int unsigned TgtW = $clog2(NSLAVE + 1);

    logic [TgtW-1:0] dec_idx, tgt, last_tgt_q, head;
    logic            dec_hit, allow, gnt_sel, push, pop;
    logic            fifo_full, fifo_empty, rvalid_sel;
    logic [31:0]     rdata_sel;

    assign slv_addr_o  = addr_i;
    assign slv_we_o    = we_i;
    assign slv_be_o    = be_i;
    assign slv_wdata_o = wdata_i;

    // Ascending scan so the highest matching rule index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int r = 0; r < NRULES; r++) begin
            if (addr_i >= ADDR_RULES[r].start_addr &&
                (ADDR_RULES[r].end_addr <= ADDR_RULES[r].start_addr ||
                 addr_i < ADDR_RULES[r].end_addr)) begin
                dec_hit = 1'b1;
                dec_idx = TgtW'(ADDR_RULES[r].idx);
            end
        end
`ifdef CEI_DEMUX_ERR_SLAVE_EN
        tgt = dec_hit ? dec_idx : TgtW'(NSLAVE);
`else
        tgt = dec_hit ? dec_idx : '0;
`endif
    end

    // A target switch waits for the FIFO to drain so responses cannot overtake each other.
    assign allow = !rst_i && !fifo_full && (fifo_empty || tgt == last_tgt_q);

    always_comb begin
        slv_req_o = '0;
        gnt_sel   = 1'b0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (tgt == TgtW'(k)) begin
                slv_req_o[k] = req_i && allow;
                gnt_sel      = slv_gnt_i[k];
            end
        end
`ifdef CEI_DEMUX_ERR_SLAVE_EN
        if (tgt == TgtW'(NSLAVE)) begin
            gnt_sel = 1'b1;
        end
`endif
    end

    assign gnt_o = allow && gnt_sel;
    assign push  = req_i && gnt_o;

    always_comb begin
        rvalid_sel = 1'b0;
        rdata_sel  = '0;
        resp_err_o = 1'b0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (!fifo_empty && head == TgtW'(k)) begin
                rvalid_sel = slv_rvalid_i[k];
                rdata_sel  = slv_rdata_i[32*k +: 32];
            end else if (slv_rvalid_i[k]) begin
                resp_err_o = !rst_i;
            end
        end
`ifdef CEI_DEMUX_ERR_SLAVE_EN
        // An error entry answers as soon as it reaches the head, i.e. the cycle after accept.
        if (!fifo_empty && head == TgtW'(NSLAVE)) begin
            rvalid_sel = 1'b1;
            rdata_sel  = CPU_DEMUX_ERR_RDATA;
        end
`endif
        rvalid_o = rvalid_sel && !rst_i;
        rdata_o  = rvalid_o ? rdata_sel : '0;
    end

    assign pop = rvalid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_tgt_q <= '0;
        end else if (push) begin
            last_tgt_q <= tgt;
        end
    end

    cei_resp_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TgtW)
    ) u_resp_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (tgt),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule
